// File: rtl/mem_pipe.sv
// mem_pipe: single-clock memory with one write port and one read port.
// After reset, or on clear_req, it sweeps zeros through every word. It has a
// configurable read latency (1 or 2) with a read_valid strobe, flags
// out-of-range addresses, and gives defined same-address collision results.
// Build option: define MEM_PIPE_BYPASS_EN for write-first collisions. The
// default build is read-first.
module mem_pipe #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned MEM_SIZE     = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_req,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  read_valid,
  output logic                  busy,
  output logic                  addr_err
);

  localparam logic [ADDR_WIDTH:0]   MEM_SIZE_L = (ADDR_WIDTH+1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR   = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  busy_q, busy_d;
  logic                  addr_err_q, addr_err_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  read_valid_q, read_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_valid_q, s1_valid_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;
  logic                  wr_in_range_s;
  logic                  rd_in_range_s;
  logic                  rd_fire_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  assign wr_in_range_s = ({1'b0, write_address} < MEM_SIZE_L);
  assign rd_in_range_s = ({1'b0, read_address} < MEM_SIZE_L);

  // Next-state logic: sweep/ready control, port acceptance and the read pipeline.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    busy_d       = busy_q;
    addr_err_d   = 1'b0;
    mem_we_s     = 1'b0;
    mem_waddr_s  = ptr_q;
    mem_wdata_s  = '0;
    rd_fire_s    = 1'b0;
    rd_word_s    = '0;
    s1_valid_d   = 1'b0;
    s1_data_d    = s1_data_q;
    read_valid_d = 1'b0;
    data_out_d   = data_out_q;

    case (state_q)
      CLEAR: begin
        // One word zeroed per cycle. All port requests are ignored.
        mem_we_s    = 1'b1;
        mem_waddr_s = ptr_q;
        mem_wdata_s = '0;
        if (ptr_q == LAST_PTR) begin
          state_d = READY;
          busy_d  = 1'b0;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + ADDR_WIDTH'(1);
        end
      end
      READY: begin
        if (clear_req) begin
          // Re-clear wins over any access in the same cycle.
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
        end else begin
          if (write_en && wr_in_range_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = write_address;
            mem_wdata_s = data_in;
          end else begin
            mem_we_s    = 1'b0;
          end
          rd_fire_s  = read_en;
          addr_err_d = (write_en && !wr_in_range_s) || (read_en && !rd_in_range_s);
          if (read_en && rd_in_range_s) begin
`ifdef MEM_PIPE_BYPASS_EN
            if (write_en && (write_address == read_address)) begin
              rd_word_s = data_in;
            end else begin
              rd_word_s = mem_q[read_address];
            end
`else
            rd_word_s = mem_q[read_address];
`endif
          end else begin
            // Out-of-range reads return zero.
            rd_word_s = '0;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
        busy_d  = 1'b1;
      end
    endcase

    // Reads already in flight drain normally, even while clearing.
    if (READ_LATENCY == 2) begin
      s1_valid_d   = rd_fire_s;
      if (rd_fire_s) begin
        s1_data_d  = rd_word_s;
      end else begin
        s1_data_d  = s1_data_q;
      end
      read_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_out_d = s1_data_q;
      end else begin
        data_out_d = data_out_q;
      end
    end else begin
      read_valid_d = rd_fire_s;
      if (rd_fire_s) begin
        data_out_d = rd_word_s;
      end else begin
        data_out_d = data_out_q;
      end
    end
  end

  // State and output registers. Reset restarts the sweep and flushes the read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= CLEAR;
      ptr_q        <= '0;
      busy_q       <= 1'b1;
      addr_err_q   <= 1'b0;
      data_out_q   <= '0;
      read_valid_q <= 1'b0;
      s1_data_q    <= '0;
      s1_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      busy_q       <= busy_d;
      addr_err_q   <= addr_err_d;
      data_out_q   <= data_out_d;
      read_valid_q <= read_valid_d;
      s1_data_q    <= s1_data_d;
      s1_valid_q   <= s1_valid_d;
    end
  end

  // Storage array. It has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we_s && !rst) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign data_out   = data_out_q;
  assign read_valid = read_valid_q;
  assign busy       = busy_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_pipe.sv
// Bench for mem_pipe. Instance A uses the default configuration (16 words,
// latency 1). Instance B uses 12 words and latency 2. Read results are
// scoreboarded with the cycle in which they are due.
module tb_mem_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // Instance A signals
  logic       a_rst = 1'b1, a_clear_req = 1'b0, a_write_en = 1'b0, a_read_en = 1'b0;
  logic [3:0] a_write_address = 4'd0, a_read_address = 4'd0;
  logic [7:0] a_data_in = 8'd0;
  logic [7:0] a_data_out;
  logic       a_read_valid, a_busy, a_addr_err;

  // Instance B signals
  logic       b_rst = 1'b1, b_clear_req = 1'b0, b_write_en = 1'b0, b_read_en = 1'b0;
  logic [3:0] b_write_address = 4'd0, b_read_address = 4'd0;
  logic [7:0] b_data_in = 8'd0;
  logic [7:0] b_data_out;
  logic       b_read_valid, b_busy, b_addr_err;

  mem_pipe u_dut_a (
    .clk(clk), .rst(a_rst), .clear_req(a_clear_req),
    .write_en(a_write_en), .write_address(a_write_address), .data_in(a_data_in),
    .read_en(a_read_en), .read_address(a_read_address),
    .data_out(a_data_out), .read_valid(a_read_valid), .busy(a_busy), .addr_err(a_addr_err)
  );

  mem_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .MEM_SIZE(12), .READ_LATENCY(2)) u_dut_b (
    .clk(clk), .rst(b_rst), .clear_req(b_clear_req),
    .write_en(b_write_en), .write_address(b_write_address), .data_in(b_data_in),
    .read_en(b_read_en), .read_address(b_read_address),
    .data_out(b_data_out), .read_valid(b_read_valid), .busy(b_busy), .addr_err(b_addr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [3:0] ad, input logic [7:0] d);
    a_write_en = 1'b1; a_write_address = ad; a_data_in = d;
    tick();
    a_write_en = 1'b0;
  endtask

  task automatic a_read(input logic [3:0] ad, input logic [7:0] ex);
    a_read_en = 1'b1; a_read_address = ad;
    qa.push_back('{ex, cyc + 1});
    tick();
    a_read_en = 1'b0;
  endtask

  task automatic b_read(input logic [3:0] ad, input logic [7:0] ex);
    b_read_en = 1'b1; b_read_address = ad;
    qb.push_back('{ex, cyc + 2});
    tick();
    b_read_en = 1'b0;
  endtask

  // Scoreboard for instance A: read_valid must match the queue, and data is checked on each pop.
  always @(negedge clk) begin
    logic ev;
    exp_t e;
    ev = (qa.size() != 0) && (qa[0].due == cyc);
    if (a_read_valid || ev) begin
      chk("a_read_valid", a_read_valid, ev);
      if (ev) begin
        e = qa.pop_front();
        chk("a_data_out", a_data_out, e.data);
      end
    end
  end

  // Scoreboard for instance B.
  always @(negedge clk) begin
    logic ev;
    exp_t e;
    ev = (qb.size() != 0) && (qb[0].due == cyc);
    if (b_read_valid || ev) begin
      chk("b_read_valid", b_read_valid, ev);
      if (ev) begin
        e = qb.pop_front();
        chk("b_data_out", b_data_out, e.data);
      end
    end
  end

  initial begin
    logic [7:0] coll_exp;
`ifdef MEM_PIPE_BYPASS_EN
    coll_exp = 8'h77;
`else
    coll_exp = 8'h22;
`endif

    // Reset state
    tick(); tick();
    chk("a_reset_busy", a_busy, 1);
    chk("a_reset_valid", a_read_valid, 0);
    chk("a_reset_err", a_addr_err, 0);
    chk("a_reset_dout", a_data_out, 0);
    chk("b_reset_busy", b_busy, 1);

    // Reset sweep: accesses during busy are ignored
    a_rst = 1'b0;
    a_write_en = 1'b1; a_write_address = 4'd3; a_data_in = 8'h11;
    a_read_en = 1'b1; a_read_address = 4'd3;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("a_busy_sweep", a_busy, (i < 16));
      chk("a_err_sweep", a_addr_err, 0);
    end
    a_write_en = 1'b0; a_read_en = 1'b0;
    for (int i = 0; i < 16; i++) a_read(4'(i), 8'h00);
    tick(); tick();

    // Basic write/read
    a_write(4'd0, 8'h11);
    a_write(4'd1, 8'h22);
    a_write(4'd1, 8'hA5);
    a_read(4'd0, 8'h11);
    a_read(4'd1, 8'hA5);
    tick();
    chk("a_hold_dout", a_data_out, 8'hA5);
    chk("a_err_basic", a_addr_err, 0);

    // Collision
    a_write(4'd5, 8'h22);
    a_write_en = 1'b1; a_write_address = 4'd5; a_data_in = 8'h77;
    a_read_en = 1'b1; a_read_address = 4'd5;
    qa.push_back('{coll_exp, cyc + 1});
    tick();
    a_write_en = 1'b0; a_read_en = 1'b0;
    a_read(4'd5, 8'h77);
    tick();

    // Re-clear with a colliding write and read in the request cycle
    for (int i = 0; i < 16; i++) a_write(4'(i), 8'h5A);
    a_read(4'd9, 8'h5A);
    a_clear_req = 1'b1;
    a_write_en = 1'b1; a_write_address = 4'd2; a_data_in = 8'h99;
    a_read_en = 1'b1; a_read_address = 4'd7;
    tick();
    a_clear_req = 1'b0; a_write_en = 1'b0; a_read_en = 1'b0;
    chk("a_clear_busy0", a_busy, 1);
    chk("a_clear_keeps_dout", a_data_out, 8'h5A);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("a_busy_reclear", a_busy, (i < 16));
    end
    for (int i = 0; i < 16; i++) a_read(4'(i), 8'h00);
    tick(); tick();

    // Reset while the sweep is at ptr=7
    a_clear_req = 1'b1;
    tick();
    a_clear_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    chk("a_midclear_busy", a_busy, 1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("a_busy_restart", a_busy, (i < 16));
    end
    a_read(4'd3, 8'h00);
    tick(); tick();

    // Instance B: 12 words, latency 2
    b_rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("b_busy_sweep", b_busy, (i < 12));
    end
    b_write_en = 1'b1; b_write_address = 4'd13; b_data_in = 8'hFF;
    tick();
    b_write_en = 1'b0;
    chk("b_err_wr_oor", b_addr_err, 1);
    tick();
    chk("b_err_clears", b_addr_err, 0);
    b_write_en = 1'b1; b_write_address = 4'd11; b_data_in = 8'h3C;
    tick();
    b_write_en = 1'b0;
    chk("b_err_wr_last", b_addr_err, 0);
    b_read(4'd11, 8'h3C);
    b_read(4'd14, 8'h00);
    chk("b_err_rd_oor", b_addr_err, 1);
    b_read(4'd12, 8'h00);
    chk("b_err_rd_12", b_addr_err, 1);
    b_read(4'd1, 8'h00);
    chk("b_err_rd_ok", b_addr_err, 0);
    b_read(4'd11, 8'h3C);
    tick(); tick();
    chk("b_hold_dout", b_data_out, 8'h3C);

    // Reset with a read in flight: the read never completes
    b_read_en = 1'b1; b_read_address = 4'd11;
    tick();
    b_read_en = 1'b0;
    b_rst = 1'b1;
    tick();
    chk("b_rst_dout", b_data_out, 0);
    chk("b_rst_valid", b_read_valid, 0);
    b_rst = 1'b0;
    tick(); tick(); tick();

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_pipe.md
# mem_pipe

Parametrised single-clock, one-write/one-read-port memory for the dot-product FIFO datapath; successor to the basic synchronous buffer memory. Adds:
- hardware sweep-clear of every word after reset or on request;
- configurable read latency with a read-valid strobe;
- out-of-range address detection;
- defined same-address read/write collision behaviour.

## Interface
- DATA_WIDTH, 8, word width in bits
- ADDR_WIDTH, 4, address width in bits
- MEM_SIZE, 16, number of words; 1 ≤ MEM_SIZE ≤ 2**ADDR_WIDTH
- READ_LATENCY, 1, cycles from accepted read to data_out; legal values 1 or 2
- Timing: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- clear_req  in  1  request re-clear of all words (sampled only in READY)
- write_en  in  1  write strobe
- write_address  in  ADDR_WIDTH  write address
- data_in  in  DATA_WIDTH  write data
- read_en  in  1  read strobe
- read_address  in  ADDR_WIDTH  read address
- data_out  out  DATA_WIDTH  read data, held between reads
- read_valid  out  1  one-cycle pulse, data_out updated this cycle
- busy  out  1  high while clearing; accesses ignored
- addr_err  out  1  one-cycle pulse, an accepted access used address ≥ MEM_SIZE

## Operation
- Reset values:
  - data_out = 0, read_valid = 0, addr_err = 0, read pipeline flushed;
  - busy = 1, FSM in CLEAR, clear pointer = 0.
- FSM states: CLEAR, READY.
  - CLEAR:
    - each cycle writes 0 to word[ptr], then ptr++;
    - when ptr = MEM_SIZE-1 is written, go to READY and drop busy.
    - write_en/read_en/clear_req are ignored: no memory update, no read_valid, no addr_err.
  - READY:
    - clear_req=1 → CLEAR with ptr=0; this takes priority over a same-cycle write (the write is dropped) and read (the read is not accepted).
    - Otherwise write_en and read_en are accepted independently.
- Write: write_en with write_address < MEM_SIZE updates the word at the clock edge. Out-of-range writes are dropped and pulse addr_err.
- Read, accepted with read_en:
  - In range: the word enters the read pipeline.
  - Out of range: returns 0 with read_valid and pulses addr_err, with the same latency as a legal read.
- addr_err pulses once if either port is out of range in that cycle.
- Collision: read and write on the same in-range address in the same cycle. Result depends on MEM_PIPE_BYPASS_EN (see Configuration).
- Reads already in the pipeline when CLEAR starts complete normally, with their pre-clear data.
- rst mid-CLEAR restarts the sweep at ptr=0. rst in READY flushes the pipeline: no read_valid is emitted for pending reads.
- data_out holds its last value when read_valid=0. It is never cleared by clear_req.

## Timing
- Clear duration: busy stays 1 for exactly MEM_SIZE edges after the first edge with rst=0. The first access is accepted at the edge after busy falls.
- READ_LATENCY=1: read accepted at edge N → data_out/read_valid valid after edge N+1? No — updated at edge N, visible during cycle N→N+1. read_valid is high that cycle.
- READ_LATENCY=2: one extra register stage; data_out and read_valid update at edge N+1.
- Back-to-back reads: one per cycle, full throughput, no bubbles.
- Write visibility: a write at edge N is readable by a read accepted at edge N+1, regardless of configuration.
- addr_err is registered, high the cycle after the offending edge, and is independent of READ_LATENCY.

## Configuration
- MEM_PIPE_BYPASS_EN defined: write-first. A colliding read returns data_in of the same cycle.
- MEM_PIPE_BYPASS_EN undefined: read-first. A colliding read returns the old stored word; the new value is visible from the next read.
- No other behaviour differs between the two builds.

## Test plan
All scenarios use DATA_WIDTH=8, MEM_SIZE=16, READ_LATENCY=1 unless noted.
- Reset sweep: release rst; busy=1 for 16 cycles, then 0. Reads of all 16 addresses return 0x00 with read_valid each cycle. A write of 0x11 to addr 3 during busy is not stored; a later read of addr 3 returns 0x00.
- Basic write/read: write 0x11@0, 0x22@1, 0xA5@1, then read 0 and 1 back-to-back. Required response: 0x11 then 0xA5 on consecutive cycles; with READ_LATENCY=2, the same values one cycle later.
- Collision: hold 0x22@5; in one cycle write 0x77@5 and read 5. With MEM_PIPE_BYPASS_EN the read returns 0x77; without it, 0x22. A following read returns 0x77 in both builds.
- Re-clear: fill 0x5A in all words; assert clear_req together with a write 0x99@2. busy=1 for 16 cycles; afterwards all words read 0x00, including addr 2.
- Out of range with MEM_SIZE=12: write 0xFF@13 → addr_err pulse, no memory change. Read @14 → data_out=0x00 with read_valid, and addr_err pulse.
- Reset mid-clear and mid-read:
  - Assert rst at ptr=7 → the sweep restarts and busy lasts 16 cycles from release.
  - Assert rst with a READ_LATENCY=2 read in flight → no read_valid, data_out=0.
